sdram_phy: RTL and testbench

SDRAM_PHY -- requirements
Module: sdram_phy

---
 rtl/sdram_phy.sv | 218 +++++++++++++++++++++
 tb/tb_sdram_phy.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_phy.sv
// SDRAM PHY: registers command, address and write data onto the pins, tracks read
// latency, and sequences clock-manager phase steps for read capture alignment.
// Optional build macro SDRAM_PHY_DEBOUNCE_EN: phase_adv must stay high for 1024
// cycles before a phase step is requested.
module sdram_phy #(
  parameter int unsigned DQ_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned BA_WIDTH   = 2,
  parameter int unsigned RD_LATENCY = 3,
  parameter int unsigned PS_STEPS   = 56,
  parameter int unsigned PS_TIMEOUT = 64,
  parameter int unsigned PS_SETTLE  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // core side
  input  logic                          cke,
  input  logic                          cs_n,
  input  logic                          ras_n,
  input  logic                          cas_n,
  input  logic                          we_n,
  input  logic [DQ_WIDTH/8-1:0]         dqm,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [BA_WIDTH-1:0]           ba,
  input  logic                          wr_en,
  input  logic [DQ_WIDTH-1:0]           wr_data,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [DQ_WIDTH-1:0]           rd_data,
  // phase control
  input  logic                          phase_adv,
  input  logic                          phase_dir,
  output logic                          phase_stable,
  output logic [$clog2(PS_STEPS)-1:0]   phase_count,
  output logic                          ps_err,
  // clock manager
  output logic                          psen,
  output logic                          psincdec,
  input  logic                          psdone,
  // pin side
  output logic                          sdram_cke,
  output logic                          sdram_cs_n,
  output logic                          sdram_ras_n,
  output logic                          sdram_cas_n,
  output logic                          sdram_we_n,
  output logic [DQ_WIDTH/8-1:0]         sdram_dqm,
  output logic [ADDR_WIDTH-1:0]         sdram_a,
  output logic [BA_WIDTH-1:0]           sdram_ba,
  output logic [DQ_WIDTH-1:0]           dq_out,
  output logic [DQ_WIDTH-1:0]           dq_oe,
  input  logic [DQ_WIDTH-1:0]           dq_in
);

  localparam int unsigned PcW   = $clog2(PS_STEPS);
  localparam int unsigned TmMax = (PS_TIMEOUT > PS_SETTLE) ? PS_TIMEOUT : PS_SETTLE;
  localparam int unsigned TmW   = $clog2(TmMax + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StSettle} ps_state_e;

  logic [RD_LATENCY-1:0] rd_sr_q;
  logic [DQ_WIDTH-1:0]   cap_q;
  logic [1:0]            adv_sync_q;
  logic                  ps_req;
  ps_state_e             state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  err_q, err_d;
  logic [TmW-1:0]        timer_q, timer_d;
  logic [PcW-1:0]        pcount_q, pcount_d;

  // Pin-side command, address and write data: one-cycle registered copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_cke   <= 1'b0;
      sdram_cs_n  <= 1'b1;
      sdram_ras_n <= 1'b1;
      sdram_cas_n <= 1'b1;
      sdram_we_n  <= 1'b1;
      sdram_dqm   <= '1;
      sdram_a     <= '0;
      sdram_ba    <= '0;
      dq_out      <= '0;
      dq_oe       <= '0;
    end else begin
      sdram_cke   <= cke;
      sdram_cs_n  <= cs_n;
      sdram_ras_n <= ras_n;
      sdram_cas_n <= cas_n;
      sdram_we_n  <= we_n;
      sdram_dqm   <= dqm;
      sdram_a     <= addr;
      sdram_ba    <= ba;
      dq_out      <= wr_data;
      dq_oe       <= {DQ_WIDTH{wr_en}};
    end
  end

  // Read capture every cycle plus a latency shift register marking valid slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sr_q <= '0;
      cap_q   <= '0;
    end else begin
      rd_sr_q <= {rd_sr_q[RD_LATENCY-2:0], rd_req};
      cap_q   <= dq_in;
    end
  end

  assign rd_valid = rd_sr_q[RD_LATENCY-1];
  assign rd_data  = rd_valid ? cap_q : '0;

  // Two-flop synchroniser for the asynchronous phase_adv request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_sync_q <= '0;
    end else begin
      adv_sync_q <= {adv_sync_q[0], phase_adv};
    end
  end

`ifdef SDRAM_PHY_DEBOUNCE_EN
  logic [10:0] deb_cnt_q;

  // Count consecutive high cycles; saturating at 1024 gives one request per high period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
    end else if (!adv_sync_q[1]) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q != 11'd1024) begin
      deb_cnt_q <= deb_cnt_q + 11'd1;
    end
  end

  assign ps_req = adv_sync_q[1] && (deb_cnt_q == 11'd1023);
`else
  logic adv_prev_q;

  // Previous synchronised level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_prev_q <= 1'b0;
    end else begin
      adv_prev_q <= adv_sync_q[1];
    end
  end

  assign ps_req = adv_sync_q[1] && !adv_prev_q;
`endif

  // Phase sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      pcount_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      pcount_q <= pcount_d;
    end
  end

  // Phase sequencer next state; requests outside idle and psdone outside wait are dropped
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    err_d    = err_q;
    timer_d  = timer_q;
    pcount_d = pcount_q;
    unique case (state_q)
      StIdle: begin
        if (ps_req) begin
          state_d = StReq;
          dir_d   = phase_dir;
        end
      end
      StReq: begin
        state_d = StWait;
        timer_d = '0;
      end
      StWait: begin
        if (psdone) begin
          state_d = StSettle;
          timer_d = '0;
          if (dir_q) begin
            pcount_d = (pcount_q == PcW'(PS_STEPS - 1)) ? '0 : pcount_q + 1'b1;
          end else begin
            pcount_d = (pcount_q == '0) ? PcW'(PS_STEPS - 1) : pcount_q - 1'b1;
          end
        end else if (timer_q == TmW'(PS_TIMEOUT - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSettle: begin
        if (timer_q == TmW'(PS_SETTLE - 1)) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign psen         = (state_q == StReq);
  assign psincdec     = dir_q;
  assign phase_stable = (state_q == StIdle);
  assign phase_count  = pcount_q;
  assign ps_err       = err_q;

endmodule

// File: tb/tb_sdram_phy.sv
// Scoreboard bench for sdram_phy (default parameters): stimulus pushes expected
// read results and phase-step directions; monitors pop and compare on rd_valid/psen.
`timescale 1ns / 1ps
module tb_sdram_phy;

  localparam int RD_LAT     = 3;
  localparam int PS_SETTLE  = 16;
  localparam int PS_TIMEOUT = 64;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] data;
  } rd_exp_t;

  logic Clk_100M;
  logic rst_n;
  logic cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0] dqm;
  logic [12:0] addr;
  logic [1:0] ba;
  logic wr_en;
  logic [15:0] wr_data;
  logic rd_req;
  logic rd_valid;
  logic [15:0] rd_data;
  logic phase_adv, phase_dir, phase_stable, ps_err;
  logic [5:0] phase_count;
  logic psen, psincdec, psdone;
  logic sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0] sdram_dqm;
  logic [12:0] sdram_a;
  logic [1:0] sdram_ba;
  logic [15:0] dq_out, dq_oe, dq_in;

  logic psdone_resp, psdone_force, psdone_en;
  logic dq_auto;
  logic [15:0] dq_fixed;
  int cyc;
  int last_psen_cyc;
  int n_total, n_pass;
  rd_exp_t rd_q[$];
  logic ps_q[$];
  logic [5:0] pc_exp;

  assign psdone = psdone_resp | psdone_force;

  sdram_phy dut (
    .clk(Clk_100M), .rst_n(rst_n),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .dqm(dqm), .addr(addr), .ba(ba), .wr_en(wr_en), .wr_data(wr_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .phase_adv(phase_adv), .phase_dir(phase_dir), .phase_stable(phase_stable),
    .phase_count(phase_count), .ps_err(ps_err),
    .psen(psen), .psincdec(psincdec), .psdone(psdone),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_dqm(sdram_dqm),
    .sdram_a(sdram_a), .sdram_ba(sdram_ba), .dq_out(dq_out), .dq_oe(dq_oe),
    .dq_in(dq_in)
  );

  initial begin
    Clk_100M = 1'b0;
    forever #5 Clk_100M = ~Clk_100M;
  end

  initial cyc = 0;
  always @(posedge Clk_100M) cyc <= cyc + 1;

  // dq_in: fixed pattern or a per-cycle stamp 0xC000 | cycle
  always @(posedge Clk_100M) begin
    #1 dq_in = dq_auto ? (16'hC000 | 16'(cyc & 32'h0FFF)) : dq_fixed;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge Clk_100M);
    #1;
  endtask

  // Read and phase-step monitor
  always @(negedge Clk_100M) begin
    if (rst_n === 1'b1) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_valid_unexpected", {63'd0, rd_valid}, 64'd0);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rd_cycle", 64'(cyc), 64'(e.cyc));
          check("rd_data", 64'(rd_data), 64'(e.data));
        end
      end
      if (psen) begin
        last_psen_cyc = cyc;
        if (ps_q.size() == 0) begin
          check("psen_unexpected", {63'd0, psen}, 64'd0);
        end else begin
          logic d;
          d = ps_q.pop_front();
          check("psincdec", {63'd0, psincdec}, {63'd0, d});
        end
      end
    end
  end

  // Clock-manager model: psdone one cycle wide, three cycles after psen
  initial begin
    psdone_resp = 1'b0;
    forever begin
      @(negedge Clk_100M);
      if (psen && psdone_en) begin
        repeat (3) @(posedge Clk_100M);
        #1 psdone_resp = 1'b1;
        @(posedge Clk_100M);
        #1 psdone_resp = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_reset_vals();
    check("rst_cmd", 64'({sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}),
          64'b01111);
    check("rst_dqm", 64'(sdram_dqm), 64'h3);
    check("rst_a_ba", 64'({sdram_a, sdram_ba}), 64'h0);
    check("rst_dq", 64'({dq_out, dq_oe}), 64'h0);
    check("rst_rd", 64'({rd_valid, rd_data}), 64'h0);
    check("rst_ps", 64'({psen, psincdec, ps_err, phase_stable}), 64'b0001);
    check("rst_phase_count", 64'(phase_count), 64'h0);
  endtask

  task automatic write_vec(input logic we, input logic [15:0] wd, input logic [4:0] cmd,
                           input logic [1:0] m, input logic [12:0] a, input logic [1:0] b);
    logic [12:0] prev_a;
    prev_a = sdram_a;
    {cke, cs_n, ras_n, cas_n, we_n} = cmd;
    wr_en = we; wr_data = wd; dqm = m; addr = a; ba = b;
    #1 check("a_hold", 64'(sdram_a), 64'(prev_a));
    step();
    check("cmd_pins", 64'({sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}),
          64'(cmd));
    check("dqm_pin", 64'(sdram_dqm), 64'(m));
    check("a_ba_pins", 64'({sdram_a, sdram_ba}), 64'({a, b}));
    check("dq_out", 64'(dq_out), 64'(wd));
    check("dq_oe", 64'(dq_oe), we ? 64'hFFFF : 64'h0);
  endtask

  task automatic wait_stable(input int budget);
    int n;
    n = 0;
    while (!phase_stable && n < budget) begin
      step();
      n++;
    end
    check("stable_reached", {63'd0, phase_stable}, 64'd1);
  endtask

  task automatic phase_step(input logic dir, input logic [5:0] exp, input logic expect_done);
    ps_q.push_back(dir);
    phase_dir = dir;
    phase_adv = 1'b1;
    step(); step();
    phase_adv = 1'b0;
    step(); step();
    check("stable_low", {63'd0, phase_stable}, 64'd0);
    wait_stable(300);
    if (expect_done) check("step_len", 64'(cyc - last_psen_cyc), 64'(4 + PS_SETTLE));
    else check("timeout_len", 64'(cyc - last_psen_cyc), 64'(PS_TIMEOUT + 1));
    check("phase_count", 64'(phase_count), 64'(exp));
  endtask

  initial begin
    n_total = 0; n_pass = 0; last_psen_cyc = 0;
    rst_n = 1'b0;
    {cke, cs_n, ras_n, cas_n, we_n} = 5'b10111;
    dqm = 2'b00; addr = '0; ba = '0; wr_en = 1'b0; wr_data = '0; rd_req = 1'b0;
    phase_adv = 1'b0; phase_dir = 1'b1; psdone_force = 1'b0; psdone_en = 1'b1;
    dq_auto = 1'b0; dq_fixed = 16'h0000;
    step(); step(); step();
    check_reset_vals();
    rst_n = 1'b1;
    step(); step();

    // Write/command path
    write_vec(1'b1, 16'h1234, 5'b10011, 2'b00, 13'h1ABC, 2'd2);
    write_vec(1'b0, 16'h5A5A, 5'b10101, 2'b11, 13'h0400, 2'd1);
    write_vec(1'b1, 16'hFFFF, 5'b00110, 2'b10, 13'h1FFF, 2'd3);
    write_vec(1'b0, 16'h0000, 5'b10111, 2'b01, 13'h0000, 2'd0);

    // Single read against stable 0xA5A5
    dq_fixed = 16'hA5A5;
    step(); step();
    rd_q.push_back('{cyc: 32'(cyc + RD_LAT), data: 16'hA5A5});
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    repeat (6) step();

    // Back-to-back reads against per-cycle stamped data
    dq_auto = 1'b1;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      rd_q.push_back('{cyc: 32'(cyc + RD_LAT), data: 16'hC000 | 16'((cyc + 2) & 32'h0FFF)});
      rd_req = 1'b1;
      step();
    end
    rd_req = 1'b0;
    repeat (6) step();
    check("rd_all_seen", 64'(rd_q.size()), 64'd0);

    // Phase stepping, decrement wrap and full-turn increment wrap
    phase_step(1'b1, 6'd1, 1'b1);
    phase_step(1'b0, 6'd0, 1'b1);
    phase_step(1'b0, 6'd55, 1'b1);
    phase_step(1'b1, 6'd0, 1'b1);
    for (int i = 1; i <= 56; i++) phase_step(1'b1, 6'(i % 56), 1'b1);

    // Request during settle is discarded
    ps_q.push_back(1'b1);
    phase_dir = 1'b1;
    phase_adv = 1'b1;
    step(); step();
    phase_adv = 1'b0;
    for (int n = 0; n < 50 && phase_count != 6'd1; n++) step();
    phase_adv = 1'b1;
    step(); step();
    phase_adv = 1'b0;
    wait_stable(300);
    repeat (10) step();
    check("discard_count", 64'(phase_count), 64'd1);

    // psdone in idle is ignored
    psdone_force = 1'b1;
    step();
    psdone_force = 1'b0;
    repeat (3) step();
    check("idle_psdone_count", 64'(phase_count), 64'd1);
    check("idle_psdone_stable", {63'd0, phase_stable}, 64'd1);

    // Timeout, then a later request still serviced
    check("err_before", {63'd0, ps_err}, 64'd0);
    psdone_en = 1'b0;
    phase_step(1'b1, 6'd1, 1'b0);
    check("err_after_timeout", {63'd0, ps_err}, 64'd1);
    psdone_en = 1'b1;
    phase_step(1'b1, 6'd2, 1'b1);
    check("err_sticky", {63'd0, ps_err}, 64'd1);

    // Reset one cycle after rd_req while waiting for psdone
    psdone_en = 1'b0;
    ps_q.push_back(1'b1);
    phase_adv = 1'b1;
    step(); step();
    phase_adv = 1'b0;
    repeat (5) step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    step(); step();
    rst_n = 1'b1;
    repeat (20) step();
    check("post_rst_stable", {63'd0, phase_stable}, 64'd1);
    check("post_rst_count", 64'(phase_count), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("ps_q_empty", 64'(ps_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
